// File: rtl/xup_tri_bus_arbiter.sv
// xup_tri_bus_arbiter
//   Round-robin arbiter that shares one SIZE-bit tri-state bus among CHANNELS
//   sources. Each channel has its own active-low tri-state driver onto y. A
//   registered FSM (IDLE/DRIVE/TURN) inserts GAP all-off turnaround cycles
//   between owners so the drivers never overlap. MAX_BURST bounds how long an
//   owner may hold the bus while another channel is waiting.
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   req       per-channel level request
//   a         channel data, channel c = a[c*SIZE +: SIZE]
//   grant     one-hot registered grant, all 0 when nobody drives
//   enable_n  registered active-low driver enables (~grant)
//   y         shared tri-state bus, 'z when every enable_n is 1
//   bus_idle  1 in IDLE and TURN
`timescale 1ns/1ps
module xup_tri_bus_arbiter #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DELAY     = 3,
  parameter int unsigned GAP       = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      req,
  input  logic [CHANNELS*SIZE-1:0] a,
  output logic [CHANNELS-1:0]      grant,
  output logic [CHANNELS-1:0]      enable_n,
  output tri   [SIZE-1:0]          y,
  output logic                     bus_idle
);

  localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned GW = $clog2(GAP) + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [PW-1:0] owner, owner_nx;
  logic [BW-1:0] burst_cnt, burst_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [CHANNELS-1:0] grant_nx;

  logic [PW-1:0] win, idx;
  logic          win_any;
  logic          take;
  logic          burst_last;
  logic          others;

  // Rotating priority search: first requester at or after ptr, wrapping.
  always_comb begin
    win     = '0;
    win_any = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = PW'((32'(ptr) + i) % CHANNELS);
      if (!win_any && req[idx]) begin
        win     = idx;
        win_any = 1'b1;
      end
    end
  end

  assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));
  assign others     = |(req & ~grant);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    burst_nx = burst_cnt;
    gap_nx   = gap_cnt;
    grant_nx = grant;
    take     = 1'b0;

    unique case (state)
      IDLE: take = win_any;
      DRIVE: begin
        // Owner drop and burst expiry on the same edge collapse into one TURN.
        if (!req[owner] || (burst_last && others)) begin
          state_nx = TURN;
          grant_nx = '0;
          gap_nx   = GW'(GAP - 1);
          burst_nx = '0;
        end else if (burst_last) begin
          burst_nx = '0;
        end else begin
          burst_nx = burst_cnt + 1'b1;
        end
      end
      TURN: begin
        if (gap_cnt == '0) begin
          take = win_any;
          if (!win_any) state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (take) begin
      state_nx      = DRIVE;
      owner_nx      = win;
      ptr_nx        = (win == PW'(CHANNELS - 1)) ? '0 : win + 1'b1;
      burst_nx      = '0;
      grant_nx      = '0;
      grant_nx[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      enable_n  <= '1;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_nx;
      gap_cnt   <= gap_nx;
      grant     <= grant_nx;
      enable_n  <= ~grant_nx;
    end
  end

  assign bus_idle = (state != DRIVE);

  // One tri-state driver per channel onto the shared wired bus.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_drv
    assign #DELAY y = ~enable_n[c] ? a[c*SIZE +: SIZE] : 'z;
  end

endmodule

// File: tb/tb_xup_tri_bus_arbiter.sv
`timescale 1ns/1ps
module tb_xup_tri_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req2;
  logic [15:0] a, a2;
  logic [3:0]  grant, enable_n, grant2, enable_n2;
  wire  [3:0]  y, y2;
  logic        bus_idle, bus_idle2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  xup_tri_bus_arbiter #(.SIZE(4), .CHANNELS(4), .DELAY(3), .GAP(1), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .req(req), .a(a),
    .grant(grant), .enable_n(enable_n), .y(y), .bus_idle(bus_idle)
  );

  xup_tri_bus_arbiter #(.SIZE(4), .CHANNELS(4), .DELAY(3), .GAP(3), .MAX_BURST(8)) dut_gap3 (
    .clk(clk), .reset(reset), .req(req2), .a(a2),
    .grant(grant2), .enable_n(enable_n2), .y(y2), .bus_idle(bus_idle2)
  );

  // Invariants sampled every cycle on both instances.
  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(grant) || (enable_n !== ~grant)) begin
      n_fail++;
      $display("FAIL inv_dut: grant=%b enable_n=%b, need onehot0 grant and enable_n=~grant", grant, enable_n);
    end
    n_checks++;
    if (!$onehot0(grant2) || (enable_n2 !== ~grant2)) begin
      n_fail++;
      $display("FAIL inv_gap3: grant=%b enable_n=%b, need onehot0 grant and enable_n=~grant", grant2, enable_n2);
    end
    if (grant != 4'b0000) begin
      n_checks++;
      if ($isunknown(y)) begin
        n_fail++;
        $display("FAIL inv_y_known: y=%b while grant=%b", y, grant);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    req2  = '0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b need 0000", grant); end
    n_checks++;
    if (enable_n !== 4'hF) begin n_fail++; $display("FAIL reset_enable_n: got %h need f", enable_n); end
    n_checks++;
    if (bus_idle !== 1'b1) begin n_fail++; $display("FAIL reset_bus_idle: got %b need 1", bus_idle); end
    n_checks++;
    if (grant2 !== 4'b0000) begin n_fail++; $display("FAIL reset_grant_gap3: got %b need 0000", grant2); end
    #2 reset = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL mid_drive_grant: got %b need 0100", grant); end
    n_checks++;
    if (y !== 4'hA) begin n_fail++; $display("FAIL mid_drive_y: got %h need a", y); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL async_reset_grant: got %b need 0000", grant); end
    n_checks++;
    if (enable_n !== 4'hF) begin n_fail++; $display("FAIL async_reset_enable_n: got %h need f", enable_n); end
    req = 4'b0000;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got %b need 1", bus_idle); end
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL post_reset_grant: got %b need 0000", grant); end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b need 0001", grant); end
    n_checks++;
    if (enable_n !== 4'b1110) begin n_fail++; $display("FAIL single_enable_n: got %b need 1110", enable_n); end
    n_checks++;
    if (y !== 4'h3) begin n_fail++; $display("FAIL single_y: got %h need 3", y); end
    n_checks++;
    if (bus_idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b need 0", bus_idle); end
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || bus_idle !== 1'b1) begin
      n_fail++; $display("FAIL single_turn: got grant=%b idle=%b need 0000/1", grant, bus_idle);
    end
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000 || bus_idle !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: got grant=%b idle=%b need 0000/1", grant, bus_idle);
    end
    // Former owner regains the bus when it is the only requester.
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_regrant: got %b need 0001", grant); end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    @(negedge clk);
    req = 4'hF;
    for (int r = 0; r < 5; r++) begin
      exp_g = 4'b0001 << (r % 4);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        n_checks++;
        if (grant !== exp_g) begin
          n_fail++; $display("FAIL rot_grant r%0d c%0d: got %b need %b", r, c, grant, exp_g);
        end
        n_checks++;
        if (y !== a[(r % 4)*4 +: 4]) begin
          n_fail++; $display("FAIL rot_y r%0d c%0d: got %h need %h", r, c, y, a[(r % 4)*4 +: 4]);
        end
        if (r == 4 && c == 7) req = 4'b0000;
      end
      @(negedge clk);
      n_checks++;
      if (enable_n !== 4'hF) begin
        n_fail++; $display("FAIL rot_gap r%0d: got enable_n=%h need f", r, enable_n);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single_hold();
    do_reset();
    @(negedge clk);
    req = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b1000 || y !== 4'hD) begin
        n_fail++; $display("FAIL hold c%0d: got grant=%b y=%h need 1000/d", i, grant, y);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_drop_at_expiry();
    do_reset();
    @(negedge clk);
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0001) begin n_fail++; $display("FAIL expiry_hold c%0d: got %b need 0001", c, grant); end
    end
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL expiry_turn: got %b need 0000", grant); end
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL expiry_single_gap: got %b need 0010", grant); end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_gap3();
    do_reset();
    @(negedge clk);
    req2 = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (grant2 !== 4'b0010 || y2 !== 4'h9) begin
      n_fail++; $display("FAIL gap3_first: got grant=%b y=%h need 0010/9", grant2, y2);
    end
    req2 = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (enable_n2 !== 4'hF) begin
        n_fail++; $display("FAIL gap3_off c%0d: got enable_n=%h need f", c, enable_n2);
      end
    end
    @(negedge clk);
    n_checks++;
    if (grant2 !== 4'b0100 || y2 !== 4'hE) begin
      n_fail++; $display("FAIL gap3_next: got grant=%b y=%h need 0100/e", grant2, y2);
    end
    req2 = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    req2  = '0;
    a     = 16'hDA53;
    a2    = 16'h7E91;
    test_reset();
    test_reset_mid_drive();
    test_single();
    test_rotation();
    test_single_hold();
    test_drop_at_expiry();
    test_gap3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
